// File: rtl/irq_sequencer_if.sv
// rtl/irq_sequencer_if.sv - interrupt request / dispatch signal bundle for irq_sequencer
interface irq_sequencer_if #(
    parameter int N_IRQ = 4
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic [5:0]       op;
    logic             op_valid;
    logic             interrupt;
    logic [15:0]      vector;
    logic [2:0]       irq_id;
    logic             in_service;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;

    modport master (
        output irq_in, mask_we, mask_wdata, op, op_valid,
        input  interrupt, vector, irq_id, in_service, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, op, op_valid,
        output interrupt, vector, irq_id, in_service, pending, mask
    );
endinterface

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - fixed-priority interrupt arbiter and entry/exit sequencer
module irq_sequencer #(
    parameter int          N_IRQ       = 4,
    parameter logic [15:0] VEC_BASE    = 16'hF000,
    parameter int          VEC_SHIFT   = 4,
    parameter logic [5:0]  RET_OP      = 6'b010000,
    parameter int          HOLD_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    irq_sequencer_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIRE    = 2'd1,
        S_HOLD    = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N_IRQ-1:0] r_irq_prev;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [2:0]       r_irq_id;
    logic [15:0]      r_vector;
    logic [HW-1:0]    r_hold;

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_eligible;
    logic [2:0]       w_winner;
    logic             w_hold_done;
    logic             w_ret;
    logic             w_interrupt;
    logic             w_in_service;

    assign w_rise      = bus.irq_in & ~r_irq_prev;
    assign w_clr       = (r_state == S_FIRE) ? (N_IRQ'(1) << r_irq_id) : '0;
    // r_mask is the pre-write value, so a same-cycle mask write only affects later arbitration
    assign w_eligible  = r_pending & ~r_mask;
    assign w_hold_done = (r_hold == HW'(HOLD_CYCLES - 1));
    assign w_ret       = bus.op_valid && (bus.op == RET_OP);

    always_comb begin
        w_winner = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (|w_eligible) w_state_next = S_FIRE;
            S_FIRE:    w_state_next = S_HOLD;
            S_HOLD:    if (w_hold_done) w_state_next = S_SERVICE;
            S_SERVICE: if (w_ret) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_interrupt  = 1'b0;
        w_in_service = 1'b0;
        case (r_state)
            S_FIRE:    w_interrupt  = 1'b1;
            S_HOLD:    w_in_service = 1'b1;
            S_SERVICE: w_in_service = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '1;
            r_irq_id   <= 3'd0;
            r_vector   <= VEC_BASE;
            r_hold     <= '0;
        end else begin
            r_irq_prev <= bus.irq_in;
            // a new edge on the source being dispatched survives the clear
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end
            if (r_state == S_IDLE && |w_eligible) begin
                r_irq_id <= w_winner;
                r_vector <= VEC_BASE + (16'(w_winner) << VEC_SHIFT);
            end
            if (r_state == S_HOLD && !w_hold_done) begin
                r_hold <= r_hold + HW'(1);
            end else begin
                r_hold <= '0;
            end
        end
    end

    assign bus.interrupt  = w_interrupt;
    assign bus.in_service = w_in_service;
    assign bus.vector     = r_vector;
    assign bus.irq_id     = r_irq_id;
    assign bus.pending    = r_pending;
    assign bus.mask       = r_mask;
endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed scoreboard bench for irq_sequencer
module tb_irq_sequencer;
    typedef struct {
        logic [2:0]  id;
        logic [15:0] vec;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   n_fires;
    exp_t exp_q[$];

    irq_sequencer_if #(.N_IRQ(4)) intf();

    irq_sequencer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (intf.interrupt === 1'b1) n_fires++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 3'(id);
        e.vec = 16'hF000 + 16'(id * 16);
        exp_q.push_back(e);
    endtask

    task automatic wait_fire(input string tag, input int exp_lat);
        int   n;
        logic seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = (intf.interrupt === 1'b1);
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_q"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_lat"}, 32'(n), 32'(exp_lat));
                check({tag, "_id"}, 32'(intf.irq_id), 32'(e.id));
                check({tag, "_vec"}, 32'(intf.vector), 32'(e.vec));
            end
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        intf.irq_in = intf.irq_in | m;
        @(negedge clk);
        intf.irq_in = intf.irq_in & ~m;
    endtask

    task automatic write_mask(input logic [3:0] m);
        intf.mask_we    = 1'b1;
        intf.mask_wdata = m;
        @(negedge clk);
        intf.mask_we    = 1'b0;
    endtask

    task automatic to_service(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_insvc"}, 32'(intf.in_service), 32'd1);
        check({tag, "_int0"}, 32'(intf.interrupt), 32'd0);
    endtask

    task automatic do_ret(input string tag);
        intf.op       = 6'b010000;
        intf.op_valid = 1'b1;
        @(negedge clk);
        intf.op_valid = 1'b0;
        intf.op       = 6'd0;
        check({tag, "_ret_insvc"}, 32'(intf.in_service), 32'd0);
    endtask

    initial begin
        int f0;
        total           = 0;
        bad             = 0;
        n_fires         = 0;
        rst_n           = 1'b0;
        intf.irq_in     = '0;
        intf.mask_we    = 1'b0;
        intf.mask_wdata = '0;
        intf.op         = 6'd0;
        intf.op_valid   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_int", 32'(intf.interrupt), 32'd0);
        check("rst_vec", 32'(intf.vector), 32'hF000);
        check("rst_id", 32'(intf.irq_id), 32'd0);
        check("rst_insvc", 32'(intf.in_service), 32'd0);
        check("rst_pend", 32'(intf.pending), 32'd0);
        check("rst_mask", 32'(intf.mask), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);

        // single source, plus RET ignored in HOLD and RET without op_valid
        write_mask(4'b0000);
        check("t1_mask", 32'(intf.mask), 32'd0);
        push_exp(2);
        intf.irq_in[2] = 1'b1;
        @(negedge clk);
        intf.irq_in[2] = 1'b0;
        check("t1_pend", 32'(intf.pending), 32'b0100);
        check("t1_nofire", 32'(intf.interrupt), 32'd0);
        wait_fire("t1", 1);
        intf.op       = 6'b010000;
        intf.op_valid = 1'b1;
        @(negedge clk);
        check("t1_pend_clr", 32'(intf.pending), 32'd0);
        check("t1_hold_insvc", 32'(intf.in_service), 32'd1);
        @(negedge clk);
        intf.op_valid = 1'b0;
        @(negedge clk);
        check("t4_hold_ret_ignored", 32'(intf.in_service), 32'd1);
        @(negedge clk);
        check("t4_novalid_ret_ignored", 32'(intf.in_service), 32'd1);
        check("t1_vec_held", 32'(intf.vector), 32'hF020);
        intf.op = 6'd0;
        do_ret("t1");

        // simultaneous sources, priority and back-to-back dispatch
        push_exp(1);
        push_exp(3);
        pulse(4'b1010);
        wait_fire("t2a", 1);
        check("t2_pend3", 32'(intf.pending), 32'b1010);
        to_service("t2a");
        do_ret("t2a");
        wait_fire("t2b", 1);
        to_service("t2b");
        do_ret("t2b");

        // masked source latches pending, fires after unmask
        write_mask(4'b0001);
        f0 = n_fires;
        pulse(4'b0001);
        check("t3_pend", 32'(intf.pending), 32'b0001);
        repeat (5) @(negedge clk);
        check("t3_masked_nofire", 32'(n_fires - f0), 32'd0);
        push_exp(0);
        write_mask(4'b0000);
        wait_fire("t3", 1);
        to_service("t3");
        do_ret("t3");

        // level held high produces a single dispatch
        f0 = n_fires;
        push_exp(0);
        intf.irq_in[0] = 1'b1;
        wait_fire("t5", 2);
        to_service("t5");
        do_ret("t5");
        repeat (14) @(negedge clk);
        intf.irq_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_one_fire", 32'(n_fires - f0), 32'd1);
        check("t5_pend", 32'(intf.pending), 32'd0);

        // async reset while in service
        push_exp(3);
        pulse(4'b1000);
        wait_fire("t6", 1);
        to_service("t6");
        pulse(4'b0010);
        check("t6_pend_pre", 32'(intf.pending), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_insvc", 32'(intf.in_service), 32'd0);
        check("t6_pend", 32'(intf.pending), 32'd0);
        check("t6_int", 32'(intf.interrupt), 32'd0);
        check("t6_vec", 32'(intf.vector), 32'hF000);
        check("t6_id", 32'(intf.irq_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        f0 = n_fires;
        repeat (3) @(negedge clk);
        check("t6_mask_after", 32'(intf.mask), 32'hF);
        check("t6_no_fire_after", 32'(n_fires - f0), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
